// File: rtl/program_loader.sv
// Serial hex-keypad program loader: assembles four strobed nibbles into a 16-bit
// instruction word and writes it to instruction memory, one word per WRITE cycle.
module program_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        finish_i,
    input  logic        strobe_i,
    input  logic [3:0]  nibble_i,
    output logic [15:0] wrAddress_o,
    output logic [15:0] wrData_o,
    output logic        wren_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] wordCount_o,
    output logic        overrun_o,
    output logic [1:0]  nibbleIndex_o
);

    // Comparing against MAX_WORDS-1 before the increment keeps the full test
    // within 16 bits even when MAX_WORDS is 65536.
    localparam logic [15:0] LastCount = 16'(MAX_WORDS - 1);

    typedef enum logic [1:0] {
        Idle,
        Load,
        Write,
        Done
    } state_t;

    state_t      state_q, state_d;
    logic        strobePrev_q;
    logic [11:0] shift_q, shift_d;
    logic [1:0]  nibbleIndex_q, nibbleIndex_d;
    logic [15:0] wrAddress_q, wrAddress_d;
    logic [15:0] wrData_q, wrData_d;
    logic [15:0] wordCount_q, wordCount_d;
    logic        overrun_q, overrun_d;
    logic        wren_q, busy_q, done_q;
    logic        strobeEdge;

    assign strobeEdge = strobe_i & ~strobePrev_q;

    // Only the three earlier nibbles are held; the fourth completes the word directly.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        nibbleIndex_d = nibbleIndex_q;
        wrAddress_d   = wrAddress_q;
        wrData_d      = wrData_q;
        wordCount_d   = wordCount_q;
        overrun_d     = overrun_q;

        case (state_q)
            Idle, Done: begin
                if (start_i) begin
                    state_d       = Load;
                    wrAddress_d   = 16'd0;
                    wordCount_d   = 16'd0;
                    nibbleIndex_d = 2'd0;
                    shift_d       = 12'd0;
                    overrun_d     = 1'b0;
                end
            end
            Load: begin
                if (finish_i) begin
                    state_d       = Done;
                    nibbleIndex_d = 2'd0;
                    shift_d       = 12'd0;
                end else if (strobeEdge) begin
                    shift_d       = {shift_q[7:0], nibble_i};
                    nibbleIndex_d = nibbleIndex_q + 2'd1;
                    if (nibbleIndex_q == 2'd3) begin
                        wrData_d = {shift_q, nibble_i};
                        state_d  = Write;
                    end
                end
            end
            Write: begin
                wrAddress_d = wrAddress_q + 16'd1;
                wordCount_d = wordCount_q + 16'd1;
                if (strobeEdge) begin
                    overrun_d = 1'b1;
                end
                state_d = (wordCount_q == LastCount) ? Done : Load;
            end
            default: begin
                state_d = Idle;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q       <= Idle;
            strobePrev_q  <= 1'b1;
            shift_q       <= 12'd0;
            nibbleIndex_q <= 2'd0;
            wrAddress_q   <= 16'd0;
            wrData_q      <= 16'd0;
            wordCount_q   <= 16'd0;
            overrun_q     <= 1'b0;
            wren_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            strobePrev_q  <= strobe_i;
            shift_q       <= shift_d;
            nibbleIndex_q <= nibbleIndex_d;
            wrAddress_q   <= wrAddress_d;
            wrData_q      <= wrData_d;
            wordCount_q   <= wordCount_d;
            overrun_q     <= overrun_d;
            wren_q        <= (state_d == Write);
            busy_q        <= (state_d == Load) || (state_d == Write);
            done_q        <= (state_d == Done);
        end
    end

    assign wrAddress_o   = wrAddress_q;
    assign wrData_o      = wrData_q;
    assign wren_o        = wren_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign wordCount_o   = wordCount_q;
    assign overrun_o     = overrun_q;
    assign nibbleIndex_o = nibbleIndex_q;

endmodule
